access_sequencer: RTL and testbench

Sequential front end for the permission-authentication logic. Accepts one access request at a time (user code, file code, requested operation), presents user/file codes to the combinational permission evaluator, and checks the returned 3-bit permission mask against the requested operation. On a match it grants and supervises the operation until it completes or times out; on a mismatch it denies. Repeated denials trigger a temporary lockout.

---
 rtl/access_sequencer_pkg.sv | 33 +++
 rtl/access_sequencer_if.sv | 43 ++++
 rtl/access_sequencer_cycle_timer.sv | 33 +++
 rtl/access_sequencer.sv | 149 ++++++++++++++
 tb/tb_access_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/access_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// Module : access_seq_pkg
// Brief  : Shared state encoding, op bit positions and one-hot helper.
// Rev    : 1.0  initial release
// =============================================================================
package access_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_EVAL  = 3'd1;
    localparam logic [STATE_W-1:0] S_GRANT = 3'd2;
    localparam logic [STATE_W-1:0] S_DENY  = 3'd3;
    localparam logic [STATE_W-1:0] S_LOCK  = 3'd4;

    localparam int OP_READ  = 0;
    localparam int OP_WRITE = 1;
    localparam int OP_EXEC  = 2;
    localparam int OP_W     = 3;
    localparam int CODE_W   = 3;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [CODE_W-1:0] code_t;

    function automatic logic is_onehot(input op_t op);
        logic [1:0] ones;
        ones = {1'b0, op[OP_READ]} + {1'b0, op[OP_WRITE]} + {1'b0, op[OP_EXEC]};
        return ones == 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/access_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module : access_sequencer_if
// Brief  : Request, permission-evaluator and grant/status signals.
// Rev    : 1.0  initial release
// =============================================================================
interface access_sequencer_if #(
    parameter int MAX_FAIL = 3
);
    import access_seq_pkg::*;

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic              req_valid;
    logic              req_ready;
    code_t             req_user;
    code_t             req_file;
    op_t               req_op;
    code_t             perm_user;
    code_t             perm_file;
    op_t               perm_mask;
    logic              grant;
    op_t               active_op;
    logic              op_done;
    logic              deny;
    logic              timeout;
    logic              locked;
    logic [FAIL_W-1:0] fail_count;

    modport master (
        output req_valid, req_user, req_file, req_op, perm_mask, op_done,
        input  req_ready, perm_user, perm_file, grant, active_op,
               deny, timeout, locked, fail_count
    );

    modport slave (
        input  req_valid, req_user, req_file, req_op, perm_mask, op_done,
        output req_ready, perm_user, perm_file, grant, active_op,
               deny, timeout, locked, fail_count
    );

endinterface
`default_nettype wire

// File: rtl/access_sequencer_cycle_timer.sv
`default_nettype none
// =============================================================================
// Module : cycle_timer
// Brief  : Loadable saturating down-counter with a zero flag.
// Rev    : 1.0  initial release
// =============================================================================
module cycle_timer #(
    parameter int WIDTH = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             en,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/access_sequencer.sv
`default_nettype none
// =============================================================================
// Module : access_sequencer
// Brief  : Request sequencer: evaluates permissions, supervises grants, locks
//          out after repeated denials.
// Rev    : 1.0  initial release
// =============================================================================
module access_sequencer #(
    parameter int MAX_FAIL      = 3,
    parameter int LOCK_CYCLES   = 16,
    parameter int GRANT_TIMEOUT = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    access_sequencer_if.slave  bus
);
    import access_seq_pkg::*;

    localparam int FAIL_W    = $clog2(MAX_FAIL + 1);
    localparam int TIMER_MAX = (GRANT_TIMEOUT > LOCK_CYCLES) ? GRANT_TIMEOUT : LOCK_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;

    code_t              r_user;
    code_t              r_file;
    op_t                r_op;
    logic [FAIL_W-1:0]  r_fail;

    logic               w_op_ok;
    logic               w_permit;
    logic [FAIL_W-1:0]  w_fail_inc;
    logic               w_lock_trip;

    logic               w_req_ready;
    logic               w_grant;
    logic               w_deny;
    logic               w_locked;
    logic               w_timeout;
    logic               w_tmr_load;
    logic               w_tmr_en;
    logic [TIMER_W-1:0] w_tmr_value;
    logic               w_tmr_zero;

    assign w_op_ok     = is_onehot(r_op);
    assign w_permit    = w_op_ok && ((bus.perm_mask & r_op) != '0);
    assign w_fail_inc  = (r_fail == FAIL_W'(MAX_FAIL)) ? r_fail : r_fail + 1'b1;
    assign w_lock_trip = w_op_ok && (w_fail_inc == FAIL_W'(MAX_FAIL));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; op_done takes priority over timer expiry in GRANT
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next = S_EVAL;
            S_EVAL:  w_next = w_permit ? S_GRANT : S_DENY;
            S_GRANT: if (bus.op_done || w_tmr_zero) w_next = S_IDLE;
            S_DENY:  w_next = w_lock_trip ? S_LOCK : S_IDLE;
            S_LOCK:  if (w_tmr_zero) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode and shared-timer control
    always_comb begin
        w_req_ready = 1'b0;
        w_grant     = 1'b0;
        w_deny      = 1'b0;
        w_locked    = 1'b0;
        w_timeout   = 1'b0;
        w_tmr_en    = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = TIMER_W'(GRANT_TIMEOUT - 1);
        case (r_state)
            S_IDLE:  w_req_ready = 1'b1;
            S_EVAL:  w_tmr_load  = w_permit;
            S_GRANT: begin
                w_grant   = 1'b1;
                w_tmr_en  = 1'b1;
                w_timeout = w_tmr_zero && !bus.op_done;
            end
            S_DENY: begin
                w_deny      = 1'b1;
                w_tmr_load  = w_lock_trip;
                w_tmr_value = TIMER_W'(LOCK_CYCLES - 1);
            end
            S_LOCK: begin
                w_locked = 1'b1;
                w_tmr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture and consecutive-denial bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_user <= '0;
            r_file <= '0;
            r_op   <= '0;
            r_fail <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.req_valid) begin
                r_user <= bus.req_user;
                r_file <= bus.req_file;
                r_op   <= bus.req_op;
            end
            if ((r_state == S_EVAL) && w_permit) begin
                r_fail <= '0;
            end else if ((r_state == S_DENY) && w_op_ok) begin
                r_fail <= w_fail_inc;
            end else if ((r_state == S_LOCK) && w_tmr_zero) begin
                r_fail <= '0;
            end
        end
    end

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .en         (w_tmr_en),
        .zero       (w_tmr_zero)
    );

    assign bus.req_ready  = w_req_ready;
    assign bus.perm_user  = r_user;
    assign bus.perm_file  = r_file;
    assign bus.grant      = w_grant;
    assign bus.active_op  = w_grant ? r_op : '0;
    assign bus.deny       = w_deny;
    assign bus.timeout    = w_timeout;
    assign bus.locked     = w_locked;
    assign bus.fail_count = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_access_sequencer.sv
`default_nettype none
// =============================================================================
// Module : tb_access_sequencer
// Brief  : Directed vector table plus hand sequences for reset, lockout and timeout.
// Rev    : 1.0  initial release
// =============================================================================
module tb_access_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    access_sequencer_if #(.MAX_FAIL(3)) bus ();

    access_sequencer #(
        .MAX_FAIL      (3),
        .LOCK_CYCLES   (16),
        .GRANT_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Evaluator stand-in: user 0 has no rights, owner has all, user1 on file0 reads/writes
    function automatic logic [2:0] eval_model(input logic [2:0] u, input logic [2:0] f);
        if (u == 3'd0)                     return 3'b000;
        else if (u == f)                   return 3'b111;
        else if (u == 3'd1 && f == 3'd0)   return 3'b011;
        else                               return 3'b001;
    endfunction

    assign bus.perm_mask = eval_model(bus.perm_user, bus.perm_file);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] user;
        logic [2:0] file;
        logic [2:0] op;
        int         done_after;
        logic       exp_grant;
        int         exp_fail;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, returns just after the accept edge
    task automatic request(input logic [2:0] u, input logic [2:0] f, input logic [2:0] op);
        bus.req_valid = 1'b1;
        bus.req_user  = u;
        bus.req_file  = f;
        bus.req_op    = op;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_grant();
        bus.op_done = 1'b1;
        step();
        bus.op_done = 1'b0;
    endtask

    task automatic deny_once(input string tag, input int exp_fail);
        request(3'd2, 3'd0, 3'b010);
        step();
        check({tag, "_deny"}, int'(bus.deny), 1);
        step();
        check({tag, "_fail"}, int'(bus.fail_count), exp_fail);
    endtask

    int lock_cnt;
    int ready_in_lock;
    int gcnt;
    int to_cnt;
    int to_at;

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_user  = '0;
        bus.req_file  = '0;
        bus.req_op    = '0;
        bus.op_done   = 1'b0;

        vecs[0] = '{3'd1, 3'd0, 3'b001, 5, 1'b1, 0};
        vecs[1] = '{3'd2, 3'd0, 3'b010, 0, 1'b0, 1};
        vecs[2] = '{3'd2, 3'd0, 3'b011, 0, 1'b0, 1};
        vecs[3] = '{3'd3, 3'd3, 3'b100, 2, 1'b1, 0};
        vecs[4] = '{3'd0, 3'd5, 3'b001, 0, 1'b0, 1};
        vecs[5] = '{3'd4, 3'd4, 3'b000, 0, 1'b0, 1};
        vecs[6] = '{3'd5, 3'd1, 3'b001, 1, 1'b1, 0};
        vecs[7] = '{3'd6, 3'd6, 3'b111, 0, 1'b0, 0};
        vecs[8] = '{3'd1, 3'd0, 3'b100, 0, 1'b0, 1};
        vecs[9] = '{3'd7, 3'd2, 3'b001, 0, 1'b1, 0};

        #1;
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_fail", int'(bus.fail_count), 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            request(vecs[i].user, vecs[i].file, vecs[i].op);
            check($sformatf("v%0d_perm_user", i), int'(bus.perm_user), int'(vecs[i].user));
            check($sformatf("v%0d_perm_file", i), int'(bus.perm_file), int'(vecs[i].file));
            check($sformatf("v%0d_busy", i), int'(bus.req_ready), 0);
            step();
            check($sformatf("v%0d_grant", i), int'(bus.grant), int'(vecs[i].exp_grant));
            check($sformatf("v%0d_deny", i), int'(bus.deny), int'(!vecs[i].exp_grant));
            check($sformatf("v%0d_active_op", i), int'(bus.active_op),
                  vecs[i].exp_grant ? int'(vecs[i].op) : 0);
            if (vecs[i].exp_grant) begin
                repeat (vecs[i].done_after) step();
                check($sformatf("v%0d_held", i), int'(bus.grant), 1);
                finish_grant();
                check($sformatf("v%0d_grant_off", i), int'(bus.grant), 0);
            end else begin
                step();
                check($sformatf("v%0d_deny_pulse", i), int'(bus.deny), 0);
            end
            check($sformatf("v%0d_ready", i), int'(bus.req_ready), 1);
            check($sformatf("v%0d_fail", i), int'(bus.fail_count), vecs[i].exp_fail);
        end

        // Two denials, then a grant clears the count; reset lands mid-grant
        deny_once("pre1", 1);
        deny_once("pre2", 2);
        request(3'd1, 3'd0, 3'b001);
        step();
        check("mid_grant", int'(bus.grant), 1);
        check("grant_clears_fail", int'(bus.fail_count), 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_grant", int'(bus.grant), 0);
        check("arst_active_op", int'(bus.active_op), 0);
        check("arst_ready", int'(bus.req_ready), 1);
        check("arst_perm_user", int'(bus.perm_user), 0);
        step();
        rst = 1'b0;
        request(3'd3, 3'd3, 3'b010);
        check("post_rst_perm_user", int'(bus.perm_user), 3);
        step();
        check("post_rst_grant", int'(bus.grant), 1);
        finish_grant();

        // Lockout after three consecutive permission denials
        deny_once("lk1", 1);
        deny_once("lk2", 2);
        request(3'd2, 3'd0, 3'b010);
        step();
        check("lk3_deny", int'(bus.deny), 1);
        bus.req_valid = 1'b1;
        bus.req_user  = 3'd7;
        bus.req_file  = 3'd7;
        bus.req_op    = 3'b001;
        lock_cnt      = 0;
        ready_in_lock = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!bus.locked) break;
            lock_cnt++;
            if (bus.req_ready) ready_in_lock = 1;
        end
        check("lock_cycles", lock_cnt, 16);
        check("lock_ready_low", ready_in_lock, 0);
        check("lock_ignored", int'(bus.perm_user), 2);
        check("lock_fail_cleared", int'(bus.fail_count), 0);
        check("lock_exit_ready", int'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        check("after_lock_accept", int'(bus.perm_user), 7);
        step();
        check("after_lock_grant", int'(bus.grant), 1);
        finish_grant();

        // Grant left to expire
        request(3'd1, 3'd0, 3'b010);
        step();
        gcnt   = 0;
        to_cnt = 0;
        to_at  = 0;
        for (int i = 0; i < 100 && bus.grant; i++) begin
            gcnt++;
            if (bus.timeout) begin
                to_cnt++;
                to_at = gcnt;
            end
            step();
        end
        check("to_grant_len", gcnt, 64);
        check("to_pulses", to_cnt, 1);
        check("to_position", to_at, 64);
        check("to_ready", int'(bus.req_ready), 1);

        // op_done on the last grant cycle suppresses the timeout
        request(3'd1, 3'd0, 3'b001);
        step();
        repeat (63) step();
        check("c64_grant", int'(bus.grant), 1);
        check("c64_timeout_armed", int'(bus.timeout), 1);
        bus.op_done = 1'b1;
        #1;
        check("c64_timeout_suppressed", int'(bus.timeout), 0);
        step();
        bus.op_done = 1'b0;
        check("c64_grant_off", int'(bus.grant), 0);
        check("c64_ready", int'(bus.req_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
